// File: rtl/accum_drain_pkg.sv
// Shared definitions for the systolic accumulator drain logic: FSM encoding
// and the FIFO read latency the drain sequencer is built around.
package accum_drain_pkg;

    localparam int FIFO_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CAPT,
        S_HOLD,
        S_FIN
    } drain_state_e;

endpackage

// File: rtl/accum_drain.sv
// Drains NUM_COLS accumulator FIFOs row-major onto a valid/ready stream,
// one word per WAIT/READ/CAPT/HOLD pass.
module accum_drain
    import accum_drain_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_COLS   = 4,
    parameter int COL_WIDTH  = 2,
    parameter int ROW_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [ROW_WIDTH-1:0]           num_rows,
    input  logic [NUM_COLS-1:0]            fifo_empty,
    input  logic [NUM_COLS*WORD_WIDTH-1:0] fifo_data,
    output logic [NUM_COLS-1:0]            fifo_r_enable,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_WIDTH-1:0]          out_data,
    output logic [COL_WIDTH-1:0]           out_col,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    drain_state_e           state_q, state_d;
    logic [ROW_WIDTH-1:0]   rows_q, rows_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic [COL_WIDTH-1:0]   outCol_q, outCol_d;
    logic                   last_q, last_d;
    logic                   lastRow, lastCol;

    assign lastRow = (row_q == rows_q - ROW_WIDTH'(1));
    assign lastCol = (col_q == COL_WIDTH'(NUM_COLS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rows_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= '0;
            outCol_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            row_q    <= row_d;
            col_q    <= col_d;
            data_q   <= data_d;
            outCol_q <= outCol_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rows_d        = rows_q;
        row_d         = row_q;
        col_d         = col_q;
        data_d        = data_q;
        outCol_d      = outCol_q;
        last_d        = last_q;
        fifo_r_enable = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        rows_d  = num_rows;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_WAIT: begin
                if (!fifo_empty[col_q]) state_d = S_READ;
            end
            S_READ: begin
                // Recheck empty so a flag that rose since WAIT never sees a read.
                if (fifo_empty[col_q]) begin
                    state_d = S_WAIT;
                end else begin
                    fifo_r_enable[col_q] = 1'b1;
                    state_d              = S_CAPT;
                end
            end
            S_CAPT: begin
                data_d   = fifo_data[col_q*WORD_WIDTH +: WORD_WIDTH];
                outCol_d = col_q;
                last_d   = lastRow && lastCol;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = S_FIN;
                    end else begin
                        if (lastCol) begin
                            col_d = '0;
                            row_d = row_q + ROW_WIDTH'(1);
                        end else begin
                            col_d = col_q + COL_WIDTH'(1);
                        end
                        state_d = S_WAIT;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign out_col   = outCol_q;
    assign out_last  = last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: behavioural FIFOs with one-cycle read
// latency, a handshake recorder, and one task per scenario.
module tb_accum_drain;

    localparam int W  = 8;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [RW-1:0]   num_rows = '0;
    logic [NC-1:0]   fifo_empty;
    logic [NC*W-1:0] fifo_data;
    logic [NC-1:0]   fifo_r_enable;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_col;
    logic            out_last;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int startCyc = 0;

    logic [7:0] mem [NC][256];
    int         wrPtr [NC];
    int         rdPtr [NC];
    logic [7:0] fifoDataQ [NC];

    logic [7:0]    gotData [1024];
    logic [CW-1:0] gotCol [1024];
    logic          gotLast [1024];
    int            hsCyc [1024];
    int hsCount = 0, doneCount = 0, doneCyc = -1;
    int rdViolations = 0, readCount = 0, validCount = 0;

    accum_drain #(.WORD_WIDTH(W), .NUM_COLS(NC), .COL_WIDTH(CW), .ROW_WIDTH(RW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_rows(num_rows),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_r_enable(fifo_r_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on fifo_data the cycle after the read enable.
    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (fifo_r_enable[c]) begin
                fifoDataQ[c] <= mem[c][rdPtr[c] % 256];
                rdPtr[c]     <= rdPtr[c] + 1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            fifo_empty[c]        = (rdPtr[c] == wrPtr[c]);
            fifo_data[c*W +: W]  = fifoDataQ[c];
        end
    end

    // Record every handshake, done pulse and read-enable misuse mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready && hsCount < 1024) begin
                gotData[hsCount] = out_data;
                gotCol[hsCount]  = out_col;
                gotLast[hsCount] = out_last;
                hsCyc[hsCount]   = cyc;
                hsCount++;
            end
            if (out_valid) validCount++;
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (fifo_r_enable != '0) readCount++;
            if ($countones(fifo_r_enable) > 1 || (fifo_r_enable & fifo_empty) != '0) rdViolations++;
        end
    end

    task automatic clearFifos();
        for (int c = 0; c < NC; c++) begin
            rdPtr[c] = 0;
            wrPtr[c] = 0;
        end
    endtask

    task automatic clearRecord();
        hsCount = 0; doneCount = 0; doneCyc = -1;
        rdViolations = 0; readCount = 0; validCount = 0;
    endtask

    task automatic pushWord(input int c, input logic [7:0] d);
        mem[c][wrPtr[c]] = d;
        wrPtr[c]++;
    endtask

    task automatic pulseStart(input int rows);
        @(posedge clk); #1;
        start = 1'b1;
        num_rows = RW'(rows);
        @(posedge clk); #1;
        startCyc = cyc;
        start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int maxCyc, input string name);
        int n = 0;
        while (doneCount < target && n < maxCyc) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (doneCount < target) begin
            errors++;
            $display("[TB] FAIL %s_timeout: done count %0d, required %0d", name, doneCount, target);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (fifo_r_enable !== 4'b0000) begin errors++; $display("[TB] FAIL reset_renable: got %b want 0000", fifo_r_enable); end
        checks++; if ({out_data, out_col, out_last} !== 11'd0) begin errors++; $display("[TB] FAIL reset_outs: data %0h col %0d last %b, want all zero", out_data, out_col, out_last); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy %b valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] expD [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
        int badGaps = 0;
        clearFifos(); clearRecord(); out_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) pushWord(c, 8'(16 * c + r));
        pulseStart(2);
        waitDone(1, 100, "basic");
        checks++; if (hsCount !== 8) begin errors++; $display("[TB] FAIL basic_count: got %0d words want 8", hsCount); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gotData[i] !== expD[i] || gotCol[i] !== CW'(i % 4) || gotLast[i] !== (i == 7)) begin
                errors++;
                $display("[TB] FAIL basic_word%0d: got data %0h col %0d last %b, want %0h %0d %b",
                         i, gotData[i], gotCol[i], gotLast[i], expD[i], i % 4, (i == 7));
            end
        end
        checks++; if (hsCyc[0] !== startCyc + 3) begin errors++; $display("[TB] FAIL basic_latency: first word cycle %0d want %0d", hsCyc[0], startCyc + 3); end
        for (int i = 1; i < 8; i++) if (hsCyc[i] - hsCyc[i-1] != 4) badGaps++;
        checks++; if (badGaps !== 0) begin errors++; $display("[TB] FAIL basic_throughput: %0d gaps not 4 cycles, want 0", badGaps); end
        checks++; if (doneCyc !== hsCyc[7] + 1) begin errors++; $display("[TB] FAIL basic_done_time: done cycle %0d want %0d", doneCyc, hsCyc[7] + 1); end
        checks++; if (doneCount !== 1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_end: done count %0d busy %b want 1 0", doneCount, busy); end
    endtask

    task automatic test_empty_stall();
        logic [7:0] expD [4] = '{8'h40, 8'h41, 8'h42, 8'h43};
        clearFifos(); clearRecord(); out_ready = 1'b1;
        pushWord(0, 8'h40); pushWord(1, 8'h41); pushWord(3, 8'h43);
        pulseStart(1);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (hsCount !== 2 || out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_wait: words %0d valid %b busy %b want 2 0 1", hsCount, out_valid, busy); end
        pushWord(2, 8'h42);
        waitDone(1, 100, "stall");
        checks++; if (hsCount !== 4) begin errors++; $display("[TB] FAIL stall_count: got %0d words want 4", hsCount); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gotData[i] !== expD[i] || gotCol[i] !== CW'(i)) begin
                errors++; $display("[TB] FAIL stall_word%0d: got %0h col %0d want %0h %0d", i, gotData[i], gotCol[i], expD[i], i);
            end
        end
        checks++; if (rdViolations !== 0) begin errors++; $display("[TB] FAIL stall_read_empty: %0d bad read cycles want 0", rdViolations); end
    endtask

    task automatic test_backpressure();
        logic [7:0] expD [4] = '{8'hA5, 8'hB6, 8'hC7, 8'hD8};
        int n = 0, unstable = 0;
        clearFifos(); clearRecord(); out_ready = 1'b0;
        for (int c = 0; c < NC; c++) pushWord(c, expD[c]);
        pulseStart(1);
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_timeout: valid %b want 1", out_valid); end
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_col !== 2'd0) unstable++;
        end
        checks++; if (unstable !== 0 || hsCount !== 0) begin errors++; $display("[TB] FAIL bp_hold: %0d unstable cycles, %0d transfers, want 0 0", unstable, hsCount); end
        out_ready = 1'b1;
        waitDone(1, 100, "bp");
        checks++; if (hsCount !== 4) begin errors++; $display("[TB] FAIL bp_count: got %0d words want 4", hsCount); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gotData[i] !== expD[i] || gotCol[i] !== CW'(i)) begin
                errors++; $display("[TB] FAIL bp_word%0d: got %0h col %0d want %0h %0d", i, gotData[i], gotCol[i], expD[i], i);
            end
        end
    endtask

    task automatic test_zero_rows();
        clearFifos(); clearRecord(); out_ready = 1'b1;
        pulseStart(0);
        waitDone(1, 10, "zero");
        checks++; if (doneCyc !== startCyc) begin errors++; $display("[TB] FAIL zero_done_time: done cycle %0d want %0d", doneCyc, startCyc); end
        checks++; if (readCount !== 0 || validCount !== 0) begin errors++; $display("[TB] FAIL zero_activity: reads %0d valids %0d want 0 0", readCount, validCount); end
        checks++; if (doneCount !== 1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_end: done count %0d busy %b want 1 0", doneCount, busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] expD [4] = '{8'h90, 8'h91, 8'h92, 8'h93};
        int n = 0;
        clearFifos(); clearRecord(); out_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) pushWord(c, 8'(8'h50 + 16 * c + r));
        pulseStart(2);
        while (hsCount < 3 && n < 100) begin @(posedge clk); n++; end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (hsCount !== 3) begin errors++; $display("[TB] FAIL rst_mid_progress: got %0d words want 3", hsCount); end
        checks++; if ({busy, done, out_valid, out_last} !== 4'b0000 || fifo_r_enable !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_ctrl: busy %b done %b valid %b last %b ren %b want all 0", busy, done, out_valid, out_last, fifo_r_enable); end
        checks++; if (out_data !== 8'h00 || out_col !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_data: data %0h col %0d want 0 0", out_data, out_col); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (doneCount !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_done: done count %0d want 0", doneCount); end
        clearFifos(); clearRecord();
        for (int c = 0; c < NC; c++) pushWord(c, expD[c]);
        pulseStart(1);
        waitDone(1, 100, "rst_mid");
        checks++; if (hsCount !== 4 || doneCount !== 1) begin errors++; $display("[TB] FAIL rst_mid_restart: words %0d done %0d want 4 1", hsCount, doneCount); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gotData[i] !== expD[i] || gotCol[i] !== CW'(i) || gotLast[i] !== (i == 3)) begin
                errors++; $display("[TB] FAIL rst_mid_word%0d: got %0h col %0d last %b want %0h %0d %b", i, gotData[i], gotCol[i], gotLast[i], expD[i], i, (i == 3));
            end
        end
    endtask

    task automatic test_double_start();
        logic [7:0] expD [4] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        int bad = 0;
        clearFifos(); clearRecord(); out_ready = 1'b1;
        for (int c = 0; c < NC; c++) pushWord(c, expD[c]);
        pulseStart(1);
        repeat (2) @(posedge clk);
        pulseStart(3);
        waitDone(1, 100, "double");
        repeat (20) @(posedge clk);
        #1;
        checks++; if (hsCount !== 4 || doneCount !== 1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL double_start: words %0d done %0d busy %b want 4 1 0", hsCount, doneCount, busy); end
        for (int i = 0; i < 4; i++) if (gotData[i] !== expD[i] || gotLast[i] !== (i == 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL double_words: %0d wrong words want 0", bad); end
        num_rows = '0;
    endtask

    task automatic test_max_rows();
        int bad = 0;
        clearFifos(); clearRecord(); out_ready = 1'b1;
        for (int r = 0; r < 255; r++)
            for (int c = 0; c < NC; c++) pushWord(c, 8'(r + c));
        pulseStart(255);
        waitDone(1, 5000, "max");
        checks++; if (hsCount !== 1020 || doneCount !== 1) begin errors++; $display("[TB] FAIL max_count: words %0d done %0d want 1020 1", hsCount, doneCount); end
        for (int i = 0; i < 1020; i++)
            if (gotData[i] !== 8'(i / 4 + i % 4) || gotCol[i] !== CW'(i % 4) || gotLast[i] !== (i == 1019)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL max_words: %0d wrong words want 0", bad); end
        checks++; if (rdViolations !== 0) begin errors++; $display("[TB] FAIL max_read_rule: %0d bad read cycles want 0", rdViolations); end
    endtask

    initial begin
        clearFifos();
        test_reset();
        test_basic();
        test_empty_stall();
        test_backpressure();
        test_zero_rows();
        test_reset_mid();
        test_double_start();
        test_max_rows();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
